breakout_hit_arbiter: RTL

- Sits between the ball/racket logic (50-bit per-brick collision vector) and the brick-state store/renderer.
- Captures every brick hit, including several bricks hit in the same cycle, and serialises them into one brick-clear transaction at a time on a valid/ready port.
- Round-robin priority decides the order.
- Owns the alive mask, BCD score, bricks-remaining count and the sticky all-clear (win) flag used by the game FSM.

---
 rtl/breakout_pkg.sv | 53 +++++
 rtl/breakout_hit_arbiter_if.sv | 11 +
 rtl/breakout_rr_pick.sv | 35 +++
 rtl/breakout_hit_arbiter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/breakout_pkg.sv
// Shared constants, FSM encoding and BCD helpers for the brick-hit arbiter.
// Used by breakout_hit_arbiter and breakout_rr_pick.
package breakout_pkg;

    localparam int NUM_BRICKS = 50;
    localparam int IDX_W = 6;
    localparam int BCD_DIGIT_W = 4;
    localparam logic [15:0] SCORE_MAX = 16'h9999;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    // Four-digit BCD add; a carry out of the top digit pins the result at 9999.
    function automatic logic [15:0] bcd_add_sat(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic        carry;
        logic [4:0]  d;
        r     = 16'h0000;
        carry = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = {1'b0, a[i*BCD_DIGIT_W +: BCD_DIGIT_W]} + {1'b0, b[i*BCD_DIGIT_W +: BCD_DIGIT_W]}
                + {4'b0000, carry};
            if (d > 5'd9) begin
                d     = d - 5'd10;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            r[i*BCD_DIGIT_W +: BCD_DIGIT_W] = d[3:0];
        end
        return carry ? SCORE_MAX : r;
    endfunction

    function automatic logic [15:0] pts_to_bcd(input logic [4:0] p);
        logic [3:0] tens;
        logic [3:0] ones;
        if (p >= 5'd20) begin
            tens = 4'd2;
            ones = 4'(p - 5'd20);
        end else if (p >= 5'd10) begin
            tens = 4'd1;
            ones = 4'(p - 5'd10);
        end else begin
            tens = 4'd0;
            ones = p[3:0];
        end
        return {8'h00, tens, ones};
    endfunction

endpackage

// File: rtl/breakout_hit_arbiter_if.sv
// Brick-clear request channel: valid/index from the arbiter, ready from the brick store.
interface breakout_hit_arbiter_if #(parameter int IDX_W = 6) ();

    logic             clr_valid;
    logic [IDX_W-1:0] clr_idx;
    logic             clr_ready;

    modport master (output clr_valid, output clr_idx, input clr_ready);
    modport slave  (input clr_valid, input clr_idx, output clr_ready);

endinterface

// File: rtl/breakout_rr_pick.sv
// Combinational round-robin picker: lowest set request at or above ptr, else lowest overall.
module breakout_rr_pick
    import breakout_pkg::*;
#(
    parameter int NUM_REQ = NUM_BRICKS,
    parameter int SEL_W   = IDX_W
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   idx,
    output logic               any
);

    logic             hi_any;
    logic             lo_any;
    logic [SEL_W-1:0] hi_idx;
    logic [SEL_W-1:0] lo_idx;

    // Scan downward so the last match kept is the lowest index in each window.
    always_comb begin
        hi_any = 1'b0;
        lo_any = 1'b0;
        hi_idx = {SEL_W{1'b0}};
        lo_idx = {SEL_W{1'b0}};
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            lo_any = lo_any | req[i];
            lo_idx = req[i] ? SEL_W'(i) : lo_idx;
            hi_any = hi_any | (req[i] & (i >= int'(ptr)));
            hi_idx = (req[i] && (i >= int'(ptr))) ? SEL_W'(i) : hi_idx;
        end
        idx = hi_any ? hi_idx : lo_idx;
        any = lo_any;
    end

endmodule

// File: rtl/breakout_hit_arbiter.sv
// Captures brick hits and serialises them into one clear request at a time; owns score/alive/win.
// Optional BREAKOUT_HIT_COMBO_EN adds paddle_hit and a 1..3 combo multiplier on points.
module breakout_hit_arbiter #(
    parameter int NUM_BRICKS = breakout_pkg::NUM_BRICKS,
    parameter int IDX_W      = breakout_pkg::IDX_W,
    parameter int POINTS     = 1
) (
    input  logic                  vga_clk,
    input  logic                  sys_rst_n,
    input  logic                  game_reset,
`ifdef BREAKOUT_HIT_COMBO_EN
    input  logic                  paddle_hit,
`endif
    input  logic [NUM_BRICKS-1:0] hit_vec,
    breakout_hit_arbiter_if.master clr,
    output logic [NUM_BRICKS-1:0] alive,
    output logic [15:0]           score,
    output logic [IDX_W-1:0]      bricks_left,
    output logic                  all_clear
);
    import breakout_pkg::*;

    arb_state_t            state_r, state_nxt_s;
    logic [NUM_BRICKS-1:0] pending_r, alive_r, grant_mask_s;
    logic [IDX_W-1:0]      rr_ptr_r, rr_nxt_s, clr_idx_r, clr_idx_nxt_s, pick_idx_s, bricks_left_r;
    logic                  pick_any_s, clr_valid_r, clr_valid_nxt_s, hs_s, last_hs_s, rst_s;
    logic [15:0]           score_r, pts_bcd_s;
    logic                  all_clear_r;

    assign rst_s     = ~sys_rst_n | game_reset;
    assign hs_s      = clr_valid_r & clr.clr_ready;
    assign last_hs_s = hs_s & (bricks_left_r == IDX_W'(1));
    assign rr_nxt_s  = (clr_idx_r == IDX_W'(NUM_BRICKS - 1)) ? {IDX_W{1'b0}} : clr_idx_r + IDX_W'(1);

    breakout_rr_pick #(.NUM_REQ(NUM_BRICKS), .SEL_W(IDX_W)) u_pick (
        .req (pending_r & alive_r),
        .ptr (rr_ptr_r),
        .idx (pick_idx_s),
        .any (pick_any_s)
    );

    // One-hot of the brick being retired on a handshake cycle.
    always_comb begin
        grant_mask_s = {NUM_BRICKS{1'b0}};
        if (hs_s) begin
            grant_mask_s[clr_idx_r] = 1'b1;
        end else begin
            grant_mask_s = {NUM_BRICKS{1'b0}};
        end
    end

`ifdef BREAKOUT_HIT_COMBO_EN
    logic [1:0] combo_r;

    // Combo multiplier: paddle contact restarts it, each clear bumps it up to 3.
    always_ff @(posedge vga_clk) begin
        if (rst_s || paddle_hit) begin
            combo_r <= 2'd1;
        end else if (hs_s && (combo_r != 2'd3)) begin
            combo_r <= combo_r + 2'd1;
        end else begin
            combo_r <= combo_r;
        end
    end

    assign pts_bcd_s = pts_to_bcd(5'(POINTS * int'(combo_r)));
`else
    assign pts_bcd_s = pts_to_bcd(5'(POINTS));
`endif

    // FSM state register.
    always_ff @(posedge vga_clk) begin
        if (rst_s) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state; a handshake always passes through IDLE, which is the bubble cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = pick_any_s ? GRANT : IDLE;
            GRANT: begin
                if (last_hs_s) begin
                    state_nxt_s = DONE;
                end else if (hs_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = GRANT;
                end
            end
            DONE:    state_nxt_s = DONE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: next request valid/index; index frozen while stalled in GRANT.
    always_comb begin
        clr_valid_nxt_s = 1'b0;
        clr_idx_nxt_s   = clr_idx_r;
        case (state_r)
            IDLE: begin
                if (pick_any_s) begin
                    clr_valid_nxt_s = 1'b1;
                    clr_idx_nxt_s   = pick_idx_s;
                end else begin
                    clr_valid_nxt_s = 1'b0;
                end
            end
            GRANT:   clr_valid_nxt_s = ~hs_s;
            DONE:    clr_valid_nxt_s = 1'b0;
            default: clr_valid_nxt_s = 1'b0;
        endcase
    end

    // Registered request outputs.
    always_ff @(posedge vga_clk) begin
        if (rst_s) begin
            clr_valid_r <= 1'b0;
            clr_idx_r   <= {IDX_W{1'b0}};
        end else begin
            clr_valid_r <= clr_valid_nxt_s;
            clr_idx_r   <= clr_idx_nxt_s;
        end
    end

    // Brick bookkeeping: hit capture, retirement, score and win flag.
    always_ff @(posedge vga_clk) begin
        if (rst_s) begin
            pending_r     <= {NUM_BRICKS{1'b0}};
            alive_r       <= {NUM_BRICKS{1'b1}};
            rr_ptr_r      <= {IDX_W{1'b0}};
            score_r       <= 16'h0000;
            bricks_left_r <= IDX_W'(NUM_BRICKS);
            all_clear_r   <= 1'b0;
        end else begin
            pending_r <= (pending_r | (hit_vec & alive_r)) & ~grant_mask_s;
            alive_r   <= alive_r & ~grant_mask_s;
            if (hs_s) begin
                rr_ptr_r      <= rr_nxt_s;
                score_r       <= bcd_add_sat(score_r, pts_bcd_s);
                bricks_left_r <= bricks_left_r - IDX_W'(1);
            end else begin
                rr_ptr_r      <= rr_ptr_r;
                score_r       <= score_r;
                bricks_left_r <= bricks_left_r;
            end
            all_clear_r <= all_clear_r | last_hs_s;
        end
    end

    assign clr.clr_valid = clr_valid_r;
    assign clr.clr_idx   = clr_idx_r;
    assign alive         = alive_r;
    assign score         = score_r;
    assign bricks_left   = bricks_left_r;
    assign all_clear     = all_clear_r;

endmodule
